// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port data-memory arbiter.
// Contents: arb_state_t FSM encoding, MEM_ADDR_W / MEM_DATA_W defaults.
// Optional feature macro used by the arbiter: MEM_ARB_RR_EN (round-robin tie-break).
package mem_arb_pkg;

   localparam int MEM_ADDR_W = 8;
   localparam int MEM_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_2p_rr_pick2.sv
// Winner select between two requesters; purely combinational, zero latency.
// No backpressure of its own: the result is only used by the arbiter in IDLE.
// Ports: a_req, b_req, last_grant (1 = B granted last) in; pick_b (1 = B wins) out.
// Macro MEM_ARB_RR_EN: defined = round-robin ties, undefined = A always wins ties.
module rr_pick2 (
   input  logic a_req,
   input  logic b_req,
   input  logic last_grant,
   output logic pick_b
);

`ifdef MEM_ARB_RR_EN
   // A tie goes to the requester that was not granted last.
   assign pick_b = b_req & (~a_req | ~last_grant);
`else
   // Fixed priority: history is irrelevant, so last_grant is deliberately ignored.
   logic unused_last_grant;
   assign unused_last_grant = last_grant;
   assign pick_b            = b_req & ~a_req;
`endif

endmodule

// File: rtl/mem_arbiter_2p.sv
// Two-port arbiter/sequencer for a single-port data memory (A = fetch, B = load/store).
// Latency: req sampled in IDLE -> one ACCESS cycle -> one-cycle ack in RESP (3 cycles min).
// Backpressure: a requester holds req until its ack; the loser simply waits in IDLE.
// Ports: clk, rst (async, active-high); a_*/b_* request, command, ack and rdata;
//        Mem_Read/Mem_Write/Mem_Addr/M_W_Data/M_R_Data memory bus; grant_b owner flag.
// Macro MEM_ARB_RR_EN: defined = round-robin tie-break, undefined = A has fixed priority.
module mem_arbiter_2p
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W = MEM_ADDR_W,
   parameter int DATA_W = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_ack,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_ack,
   output logic [DATA_W-1:0] b_rdata,
   output logic              Mem_Read,
   output logic              Mem_Write,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [DATA_W-1:0] M_W_Data,
   input  logic [DATA_W-1:0] M_R_Data,
   output logic              grant_b
);

   arb_state_t        state_q;
   arb_state_t        state_d;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              last_grant;
   logic              pick_b;
   logic              start;

   // A new access starts whenever anyone is asking while we are idle.
   assign start = (state_q == IDLE) && (a_req || b_req);

`ifdef MEM_ARB_RR_EN
   // Resets to B so that A wins the very first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)        last_grant <= 1'b1;
      else if (start) last_grant <= pick_b;
   end
`else
   assign last_grant = 1'b1;
`endif

   rr_pick2 u_pick (
      .a_req      (a_req),
      .b_req      (b_req),
      .last_grant (last_grant),
      .pick_b     (pick_b)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         grant_b <= 1'b0;
         a_rdata <= '0;
         b_rdata <= '0;
      end else begin
         state_q <= state_d;
         if (start) begin
            grant_b <= pick_b;
            we_q    <= pick_b ? b_we    : a_we;
            addr_q  <= pick_b ? b_addr  : a_addr;
            wdata_q <= pick_b ? b_wdata : a_wdata;
         end
         // Read data lands only in the owner's register, and only for reads.
         if (state_q == ACCESS && !we_q) begin
            if (grant_b) b_rdata <= M_R_Data;
            else         a_rdata <= M_R_Data;
         end
      end
   end

   // Bus is decoded from the state register, so reset clears it at once and the
   // two enables are mutually exclusive by construction.
   assign Mem_Write = (state_q == ACCESS) &&  we_q;
   assign Mem_Read  = (state_q == ACCESS) && !we_q;
   assign Mem_Addr  = (state_q == ACCESS) ? addr_q  : '0;
   assign M_W_Data  = (state_q == ACCESS) ? wdata_q : '0;
   assign a_ack     = (state_q == RESP) && !grant_b;
   assign b_ack     = (state_q == RESP) &&  grant_b;

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Directed self-checking bench for mem_arbiter_2p with a small behavioural memory.
// Inputs are driven and outputs sampled on the falling edge of clk.
// Works with or without MEM_ARB_RR_EN; the continuous-request expectation follows it.
module tb_mem_arbiter_2p;
   import mem_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        a_req, a_we, b_req, b_we;
   logic [7:0]  a_addr, b_addr;
   logic [31:0] a_wdata, b_wdata;
   logic        a_ack, b_ack;
   logic [31:0] a_rdata, b_rdata;
   logic        Mem_Read, Mem_Write;
   logic [7:0]  Mem_Addr;
   logic [31:0] M_W_Data, M_R_Data;
   logic        grant_b;

   logic [31:0] mem [256];
   int          n_total;
   int          n_pass;
   logic        prev_a_ack, prev_b_ack;

   mem_arbiter_2p dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rdata(b_rdata),
      .Mem_Read(Mem_Read), .Mem_Write(Mem_Write), .Mem_Addr(Mem_Addr),
      .M_W_Data(M_W_Data), .M_R_Data(M_R_Data), .grant_b(grant_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign M_R_Data = mem[Mem_Addr];
   always @(posedge clk) if (Mem_Write) mem[Mem_Addr] <= M_W_Data;

   // Per-cycle invariants: exclusive enables and single-cycle acks.
   always @(negedge clk) begin
      n_total++;
      if (Mem_Read && Mem_Write) $display("FAIL rw_exclusive: Mem_Read=%b Mem_Write=%b, required not both 1", Mem_Read, Mem_Write);
      else n_pass++;
      n_total++;
      if ((a_ack && prev_a_ack) || (b_ack && prev_b_ack))
         $display("FAIL ack_pulse: ack held 2 cycles (a=%b b=%b), required single pulse", a_ack, b_ack);
      else n_pass++;
      prev_a_ack = a_ack;
      prev_b_ack = b_ack;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, required finish before 200us");
      $fatal(1, "timeout");
   end

   task automatic test_reset();
      int busy;
      rst = 1'b1;
      #1;
      n_total++;
      if ({Mem_Read, Mem_Write, a_ack, b_ack, grant_b} !== 5'b0)
         $display("FAIL reset_ctrl: rd/wr/aack/back/grant=%b, required 00000", {Mem_Read, Mem_Write, a_ack, b_ack, grant_b});
      else n_pass++;
      n_total++;
      if ({Mem_Addr, M_W_Data, a_rdata, b_rdata} !== 104'd0)
         $display("FAIL reset_data: addr=%h wdata=%h ardata=%h brdata=%h, required all 0", Mem_Addr, M_W_Data, a_rdata, b_rdata);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      busy = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (Mem_Read || Mem_Write || a_ack || b_ack || Mem_Addr != 0) busy++;
      end
      n_total++;
      if (busy !== 0) $display("FAIL idle_bus: %0d busy cycles with no req, required 0", busy);
      else n_pass++;
   endtask

   task automatic test_a_write_read();
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h01; a_wdata = 32'h10;
      @(negedge clk);
      a_wdata = 32'hDEAD_BEEF;  // changed after grant; must not leak onto the bus
      #1;
      n_total++;
      if ({Mem_Write, Mem_Read, Mem_Addr, M_W_Data, a_ack} !== {1'b1, 1'b0, 8'h01, 32'h10, 1'b0})
         $display("FAIL a_write_access: wr=%b rd=%b addr=%h wdata=%h ack=%b, required 1 0 01 00000010 0",
                  Mem_Write, Mem_Read, Mem_Addr, M_W_Data, a_ack);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({a_ack, b_ack, Mem_Write, Mem_Read} !== 4'b1000)
         $display("FAIL a_write_ack: aack/back/wr/rd=%b, required 1000", {a_ack, b_ack, Mem_Write, Mem_Read});
      else n_pass++;
      a_req = 1'b0;
      @(negedge clk);
      n_total++;
      if (mem[1] !== 32'h10) $display("FAIL a_write_mem: mem[1]=%h, required 00000010", mem[1]);
      else n_pass++;
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
      @(negedge clk);
      n_total++;
      if ({Mem_Read, Mem_Write, Mem_Addr} !== {1'b1, 1'b0, 8'h01})
         $display("FAIL a_read_access: rd=%b wr=%b addr=%h, required 1 0 01", Mem_Read, Mem_Write, Mem_Addr);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({a_ack, a_rdata} !== {1'b1, 32'h10})
         $display("FAIL a_read_data: ack=%b rdata=%h, required 1 00000010", a_ack, a_rdata);
      else n_pass++;
      a_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_b_single();
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h02; b_wdata = 32'h55;
      @(negedge clk);
      n_total++;
      if ({grant_b, Mem_Write, Mem_Addr, M_W_Data} !== {1'b1, 1'b1, 8'h02, 32'h55})
         $display("FAIL b_write_access: grant=%b wr=%b addr=%h wdata=%h, required 1 1 02 00000055",
                  grant_b, Mem_Write, Mem_Addr, M_W_Data);
      else n_pass++;
      @(negedge clk);
      b_req = 1'b0;
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if ({b_ack, a_ack, b_rdata, a_rdata} !== {1'b1, 1'b0, 32'h55, 32'h10})
         $display("FAIL b_read_data: back=%b aack=%b brdata=%h ardata=%h, required 1 0 00000055 00000010",
                  b_ack, a_ack, b_rdata, a_rdata);
      else n_pass++;
      b_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_tie();
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h00; a_wdata = 32'h100;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h00;
      @(negedge clk);
      n_total++;
      if ({grant_b, Mem_Write, Mem_Addr, M_W_Data} !== {1'b0, 1'b1, 8'h00, 32'h100})
         $display("FAIL tie_first_a: grant=%b wr=%b addr=%h wdata=%h, required 0 1 00 00000100",
                  grant_b, Mem_Write, Mem_Addr, M_W_Data);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({a_ack, b_ack} !== 2'b10) $display("FAIL tie_ack_a: aack/back=%b, required 10", {a_ack, b_ack});
      else n_pass++;
      a_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++;
      if ({grant_b, Mem_Read, Mem_Addr} !== {1'b1, 1'b1, 8'h00})
         $display("FAIL tie_then_b: grant=%b rd=%b addr=%h, required 1 1 00", grant_b, Mem_Read, Mem_Addr);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if ({b_ack, b_rdata, a_rdata} !== {1'b1, 32'h100, 32'h10})
         $display("FAIL tie_b_data: back=%b brdata=%h ardata=%h, required 1 00000100 00000010", b_ack, b_rdata, a_rdata);
      else n_pass++;
      b_req = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_continuous();
      int  n_acks;
      logic [3:0] order;   // bit k = owner of k-th ack (1 = B)
      logic [3:0] expect_order;
      n_acks = 0;
      order  = 4'b0;
`ifdef MEM_ARB_RR_EN
      expect_order = 4'b1010;  // B was granted last, so A, B, A, B
`else
      expect_order = 4'b0000;  // A keeps winning
`endif
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b0; a_addr = 8'h01;
      b_req = 1'b1; b_we = 1'b0; b_addr = 8'h02;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) begin
            if (n_acks < 4) order[n_acks] = b_ack;
            n_acks++;
         end
      end
      a_req = 1'b0;
      b_req = 1'b0;
      n_total++;
      if (n_acks !== 4) $display("FAIL cont_ack_count: %0d acks in 12 cycles, required 4", n_acks);
      else n_pass++;
      n_total++;
      if (order !== expect_order) $display("FAIL cont_order: owners=%b, required %b", order, expect_order);
      else n_pass++;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset_midwrite();
      int acks;
      acks = 0;
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 32'h77;
      @(negedge clk);
      n_total++;
      if (Mem_Write !== 1'b1) $display("FAIL rst_pre_write: wr=%b, required 1", Mem_Write);
      else n_pass++;
      rst = 1'b1;
      a_req = 1'b0;
      #1;
      n_total++;
      if ({Mem_Write, Mem_Read, Mem_Addr, M_W_Data} !== 42'd0)
         $display("FAIL rst_async: wr=%b rd=%b addr=%h wdata=%h, required all 0", Mem_Write, Mem_Read, Mem_Addr, M_W_Data);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (a_ack || b_ack) acks++;
      end
      n_total++;
      if (acks !== 0) $display("FAIL rst_no_ack: %0d acks after truncated write, required 0", acks);
      else n_pass++;
      n_total++;
      if (mem[5] !== 32'h0) $display("FAIL rst_no_write: mem[5]=%h, required 00000000", mem[5]);
      else n_pass++;
      n_total++;
      if (dut.state_q !== IDLE) $display("FAIL rst_state: state=%0d, required %0d (IDLE)", dut.state_q, IDLE);
      else n_pass++;
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      prev_a_ack = 1'b0;
      prev_b_ack = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      a_req = 1'b0; a_we = 1'b0; a_addr = 8'h0; a_wdata = 32'h0;
      b_req = 1'b0; b_we = 1'b0; b_addr = 8'h0; b_wdata = 32'h0;
      test_reset();
      test_a_write_read();
      test_b_single();
      test_tie();
      test_continuous();
      test_reset_midwrite();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
